// File: rtl/sram22_pkg.sv
// Shared sram22 definitions: default macro geometry and the request record
// used by the sram22 wrappers and their benches.
package sram22_pkg;

  localparam int SRAM22_DATA_WIDTH  = 64;
  localparam int SRAM22_ADDR_WIDTH  = 6;
  localparam int SRAM22_WMASK_WIDTH = 1;

  // One request on the client channel at the default geometry.
  typedef struct packed {
    logic                          we;
    logic [SRAM22_ADDR_WIDTH-1:0]  addr;
    logic [SRAM22_DATA_WIDTH-1:0]  wdata;
    logic [SRAM22_WMASK_WIDTH-1:0] wmask;
  } req_t;

endpackage

// File: rtl/sram22_rsp_fifo.sv
// Small in-order response buffer. The head entry is always visible on
// head_data; the owner guarantees no push when full and no pop when empty.
module sram22_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write on push.
  // NOTE: the storage is reset because the head entry drives the response
  // data port directly and must read as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state is assigned with <= so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/sram22_req_master.sv
// Initiator for one sram22 single-port macro: drives the macro straight from
// the request channel, captures 1-cycle-latency read data and returns it
// in order through a credit-protected response buffer.
module sram22_req_master
  import sram22_pkg::*;
#(
  parameter int DATA_WIDTH  = SRAM22_DATA_WIDTH,
  parameter int ADDR_WIDTH  = SRAM22_ADDR_WIDTH,
  parameter int WMASK_WIDTH = SRAM22_WMASK_WIDTH,
  parameter int RSP_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout,
  output logic                   busy
);

  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int CW1 = CW + 1;

  logic          fire;
  logic          rd_fire;
  logic          pop;
  logic          rd_inflight;
  logic [CW-1:0] fifo_count;
  logic [CW1-1:0] credit_used;

  // A read in flight already owns a buffer slot; a pop this cycle frees one,
  // so rsp_ready feeds req_ready combinationally to keep full throughput.
  assign pop         = rsp_valid && rsp_ready;
  assign credit_used = {1'b0, fifo_count} + CW1'(rd_inflight) - CW1'(pop);
  assign req_ready   = credit_used < CW1'(RSP_DEPTH);

  assign fire    = req_valid && req_ready;
  assign rd_fire = fire && !req_we;

  // The macro samples on the fire edge; we is gated so nothing is written
  // without a handshake.
  assign sram_we    = fire && req_we;
  assign sram_addr  = req_addr;
  assign sram_din   = req_wdata;
  assign sram_wmask = req_wmask;

  // Tracks whether sram_dout carries read data on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_inflight <= 1'b0;
    else        rd_inflight <= rd_fire;
  end

  sram22_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_inflight),
    .push_data (sram_dout),
    .pop       (pop),
    .head_data (rsp_rdata),
    .count     (fifo_count)
  );

  assign rsp_valid = fifo_count != '0;
  assign busy      = rd_inflight || (fifo_count != '0);

endmodule

// File: tb/tb_sram22_req_master.sv
// Scoreboard bench for sram22_req_master with a behavioural sram22 macro.
// Inputs change on negedge; DUT outputs are sampled 4ns later, 1ns before
// the next posedge.
module tb_sram22_req_master;
  import sram22_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [5:0]  req_addr;
  logic [63:0] req_wdata;
  logic [0:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        sram_we;
  logic [0:0]  sram_wmask;
  logic [5:0]  sram_addr;
  logic [63:0] sram_din;
  logic [63:0] sram_dout;
  logic        busy;

  sram22_req_master dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural macro: 1-cycle read latency, garbage on dout after a write.
  logic [63:0] macro_mem [64];
  always @(posedge clk) begin
    if (sram_we) begin
      if (sram_wmask[0]) macro_mem[sram_addr] <= sram_din;
      sram_dout <= 64'hBAD0_BAD0_BAD0_BAD0;
    end else begin
      sram_dout <= macro_mem[sram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    int          cyc;
    bit          strict;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] ref_mem [64];
  int          n_vec = 0;
  int          n_fail = 0;
  int          n_rsp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic req_t rd(input int a);
    return '{we: 1'b0, addr: 6'(a), wdata: 64'h0, wmask: 1'b1};
  endfunction

  function automatic req_t wr(input int a, input logic [63:0] d);
    return '{we: 1'b1, addr: 6'(a), wdata: d, wmask: 1'b1};
  endfunction

  // Present one request from a negedge until it fires; returns on a negedge.
  task automatic issue(input req_t r, input bit strict_ready, input bit strict_lat);
    int waited = 0;
    req_valid = 1'b1;
    req_we    = r.we;
    req_addr  = r.addr;
    req_wdata = r.wdata;
    req_wmask = r.wmask;
    #4;
    while (!req_ready && waited < 200) begin
      if (strict_ready) check("req_ready_stall", {63'd0, req_ready}, 64'd1);
      waited++;
      @(negedge clk);
      #4;
    end
    if (!req_ready) begin
      check("req_fire_timeout", 64'd0, 64'd1);
    end else begin
      check("sram_we_at_fire", {63'd0, sram_we}, {63'd0, r.we});
      check("sram_addr_at_fire", {58'd0, sram_addr}, {58'd0, r.addr});
      if (r.we) begin
        check("sram_din_at_fire", sram_din, r.wdata);
        ref_mem[r.addr] = r.wdata;
      end else begin
        exp_q.push_back('{data: ref_mem[r.addr], cyc: cyc + 2, strict: strict_lat});
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every response handshake and checks
  // that held response data does not change.
  initial begin
    bit          held = 1'b0;
    logic [63:0] held_data = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held && rsp_valid) check("rsp_hold", rsp_rdata, held_data);
        if (rsp_valid && rsp_ready) begin
          n_rsp++;
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", rsp_rdata, 64'hxxxx_xxxx_xxxx_xxxx);
          end else begin
            e = exp_q.pop_front();
            check("rsp_data", rsp_rdata, e.data);
            if (e.strict) check("rsp_latency", 64'(cyc), 64'(e.cyc));
          end
        end
        held      = rsp_valid && !rsp_ready;
        held_data = rsp_rdata;
      end
    end
  end

  initial begin
    int base;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #4;
      check("idle_sram_we", {63'd0, sram_we}, 64'd0);
      check("idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("idle_req_ready", {63'd0, req_ready}, 64'd1);
      check("idle_busy", {63'd0, busy}, 64'd0);
    end
    @(negedge clk);

    // Write then read the same address on the next cycle.
    base = n_rsp;
    issue(wr(5, 64'hDEAD_BEEF_0000_0001), 1'b1, 1'b0);
    issue(rd(5), 1'b1, 1'b1);
    #4;
    check("raw_busy", {63'd0, busy}, 64'd1);
    wait_drain();
    check("raw_rsp_count", 64'(n_rsp - base), 64'd1);

    // Preload through the DUT: mem[a] = a*3.
    for (int a = 0; a < 64; a++) issue(wr(a, 64'(a * 3)), 1'b1, 1'b0);

    // 64 back-to-back reads, one response per cycle.
    base = n_rsp;
    for (int a = 0; a < 64; a++) issue(rd(a), 1'b1, 1'b1);
    wait_drain();
    check("b2b_rsp_count", 64'(n_rsp - base), 64'd64);

    // Credit exhaustion with rsp_ready low: two reads accepted, third stalls.
    rsp_ready = 1'b0;
    issue(rd(10), 1'b1, 1'b0);
    issue(rd(11), 1'b1, 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 6'd12;
    for (int i = 0; i < 4; i++) begin
      #4;
      check("full_req_ready", {63'd0, req_ready}, 64'd0);
      check("full_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    issue(rd(12), 1'b0, 1'b0);
    wait_drain();

    // Write offered while the buffer is full must wait for credit.
    rsp_ready = 1'b0;
    issue(rd(20), 1'b1, 1'b0);
    issue(rd(21), 1'b1, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 6'd30;
    req_wdata = 64'h1234_5678_9ABC_DEF0;
    for (int i = 0; i < 3; i++) begin
      #4;
      check("wfull_req_ready", {63'd0, req_ready}, 64'd0);
      check("wfull_sram_we", {63'd0, sram_we}, 64'd0);
      check("wfull_mem_kept", macro_mem[30], 64'd90);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    issue(wr(30, 64'h1234_5678_9ABC_DEF0), 1'b0, 1'b0);
    issue(rd(30), 1'b1, 1'b0);
    wait_drain();

    // Reset with one response buffered and one read in flight.
    rsp_ready = 1'b0;
    issue(rd(40), 1'b1, 1'b0);
    issue(rd(41), 1'b1, 1'b0);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_rsp_rdata", rsp_rdata, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    base = n_rsp;
    repeat (5) @(negedge clk);
    check("post_rst_no_stale", 64'(n_rsp - base), 64'd0);
    issue(rd(41), 1'b1, 1'b1);
    wait_drain();
    check("post_rst_rsp_count", 64'(n_rsp - base), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Hard stop in case a wait above never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram22_req_master.md
Name: sram22_req_master

Overview:
- Initiator side of the sram22 single-port macro interface (clk, we, wmask, addr, din, dout).
- Accepts read/write requests on a valid/ready channel and drives the macro port.
- Captures the 1-cycle-latency read data and returns it on a valid/ready response channel, with a small credit-protected response buffer.
- Sits between any client and one sram22 instance; one instance per macro.

Parameters:
- DATA_WIDTH, 64, macro word width.
- ADDR_WIDTH, 6, macro address width (depth = 1<<ADDR_WIDTH).
- WMASK_WIDTH, 1, write-mask bits; each bit covers DATA_WIDTH/WMASK_WIDTH data bits.
- RSP_DEPTH, 2, response FIFO entries; must be >=2 for full read throughput.

Ports:
- clk  in  1  clock; sole clock domain, macro shares it.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid&&req_ready (fire).
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  WMASK_WIDTH  write mask (ignored for reads).
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes rsp_rdata when rsp_valid&&rsp_ready (pop).
- rsp_rdata  out  DATA_WIDTH  read data, in request order.
- sram_we  out  1  to macro we.
- sram_wmask  out  WMASK_WIDTH  to macro wmask.
- sram_addr  out  ADDR_WIDTH  to macro addr.
- sram_din  out  DATA_WIDTH  to macro din.
- sram_dout  in  DATA_WIDTH  from macro dout.
- busy  out  1  read in flight or FIFO non-empty.

Behaviour:
- Reset (async assert, sync-safe deassert): FIFO empty, rd_inflight=0, rsp_valid=0, busy=0, rsp_rdata=0. Reset mid-operation discards in-flight reads and buffered responses; no response ever appears for them.
- Macro drive is combinational from the request channel:
  - sram_addr=req_addr, sram_din=req_wdata, sram_wmask=req_wmask.
  - sram_we=fire&&req_we; sram_we=0 whenever there is no fire.
  - The macro samples on the same posedge as fire.
- Writes: complete at the fire edge. No response, no credit consumed, and sram_dout is ignored the following cycle (it is X after a write).
- Reads: fire with req_we=0 at edge t sets rd_inflight. At edge t+1, sram_dout is pushed into the FIFO and rd_inflight clears unless another read fired at t+1. rsp_valid is first high in cycle t+1..t+2, i.e. 2 edges after fire.
- Flow control:
  - req_ready = (fifo_count + rd_inflight - pop) < RSP_DEPTH, independent of req_we.
  - Combinational path rsp_ready->req_ready is intended.
  - Guarantees a push never meets a full FIFO; overflow is impossible by construction.
- FIFO:
  - In-order, rsp_rdata from the head entry.
  - Simultaneous push and pop at count=RSP_DEPTH is impossible (credit). Push and pop together at count=1 leaves count=1.
  - Pointers wrap modulo RSP_DEPTH.
  - rsp_rdata must hold stable while rsp_valid&&!rsp_ready.
- Throughput: back-to-back reads with rsp_ready=1 sustain 1 read/cycle at RSP_DEPTH=2. Interleaved writes never stall except under credit exhaustion.
- Read-after-write to the same address on consecutive cycles returns the new data (macro semantics; no forwarding needed).
- busy = rd_inflight || fifo_count!=0.

Decomposition:
- Shared package sram22_pkg: DATA_WIDTH/ADDR_WIDTH/WMASK_WIDTH defaults, and a req_t struct {we, addr, wdata, wmask} reused by the sram22 wrappers and benches.
- One sub-module: sram22_rsp_fifo (parameterised depth/width, count output, push/pop), instantiated once.
- Credit logic and macro drive stay in the top.

Test Plan:
- Reset then idle: no requests -> sram_we=0, rsp_valid=0, req_ready=1, busy=0 for 10 cycles.
- Write 0xDEAD_BEEF_0000_0001 to addr 5, then read addr 5 the next cycle -> exactly one response, 0xDEAD_BEEF_0000_0001, 2 edges after the read fire.
- 64 back-to-back reads of addr 0..63 (preloaded with data=addr*3), rsp_ready=1 -> 64 in-order responses, one per cycle, req_ready never low.
- rsp_ready=0 with 3 reads offered -> 2 accepted, req_ready low on the third. rsp_rdata stable while held. After raising rsp_ready, the third read is accepted and all 3 are returned in order.
- Write issued while the FIFO is full (rsp_ready=0): req_ready=0, so the write waits; no macro write until credit frees. Memory at that addr is unchanged until the write fires.
- Assert rst_n=0 with 1 read in flight and 1 buffered -> rsp_valid=0 immediately. After release, no stale response appears and the next read returns correct data.
